// File: rtl/usi_spi_pkg.sv
// Shared definitions for the USI SPI scheduler: state encoding, data/length
// widths, default timing parameters and the effective-length helper.
package usi_spi_pkg;

    localparam int LEN_W        = 5;
    localparam int DATA_W       = 16;

    localparam int CLK_DIV_DEF  = 2;
    localparam int CS_SETUP_DEF = 1;
    localparam int CS_HOLD_DEF  = 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        DONE
    } state_t;

    // Index of the last bit to shift. Lengths 0 and 17..31 mean a full word.
    function automatic logic [3:0] last_bit_idx(input logic [LEN_W-1:0] len);
        if (len == '0 || len > 5'd16) begin
            return 4'd15;
        end
        return 4'(len - 5'd1);
    endfunction

endpackage

// File: rtl/usi_spi_shift.sv
// Serial engine: divider, bit counter, TX/RX shift registers, sclk (mode 0).
// Ports:
//   clk, rst_b        block clock, synchronous active-low reset
//   load              latch data/len and clear RX (grant cycle)
//   run               FSM is in SHIFT
//   data, len         TX word (MSB first) and raw length
//   sd1_in            MISO
//   sclk, sd0         serial clock and MOSI
//   last              final cycle of the last bit's high phase
//   rx_data           received bits, right-aligned
module usi_spi_shift
    import usi_spi_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              load,
    input  logic              run,
    input  logic [DATA_W-1:0] data,
    input  logic [LEN_W-1:0]  len,
    input  logic              sd1_in,
    output logic              sclk,
    output logic              sd0,
    output logic              last,
    output logic [DATA_W-1:0] rx_data
);

    localparam logic [7:0] DIV_LD = 8'(CLK_DIV - 1);

    logic [7:0]        div_cnt;
    logic [3:0]        bit_cnt;
    logic              phase;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic              tc;

    assign tc      = (div_cnt == 8'd0);
    assign last    = run && phase && tc && (bit_cnt == 4'd0);
    assign sclk    = phase;
    assign sd0     = tx_sr[DATA_W-1];
    assign rx_data = rx_sr;

    // phase=0 is the sclk-low half of a bit, phase=1 the high half.
    // RX samples on the low->high transition, TX advances on high->low,
    // so MOSI only ever moves while sclk is low.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            phase   <= 1'b0;
            tx_sr   <= '0;
            rx_sr   <= '0;
        end else if (load) begin
            div_cnt <= DIV_LD;
            bit_cnt <= last_bit_idx(len);
            phase   <= 1'b0;
            tx_sr   <= data;
            rx_sr   <= '0;
        end else if (run) begin
            if (tc) begin
                div_cnt <= DIV_LD;
                phase   <= ~phase;
                if (!phase) begin
                    rx_sr <= {rx_sr[DATA_W-2:0], sd1_in};
                end else begin
                    tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
                    if (bit_cnt != 4'd0) begin
                        bit_cnt <= bit_cnt - 4'd1;
                    end
                end
            end else begin
                div_cnt <= div_cnt - 8'd1;
            end
        end
    end

endmodule

// File: rtl/usi_spi_sched.sv
// Two-requester SPI transfer scheduler: round-robin arbitration, transfer
// sequencing FSM (chip-select setup/shift/hold) and response routing.
// Ports:
//   clk, pad_cpu_rst_b          clock, synchronous active-low reset
//   en                          permits new grants
//   reqN_valid/ready/data/len   request handshake per requester
//   rspN_valid, rsp_data        one-cycle completion pulse and RX word
//   usi0_*                      serial pins and output enables
//   spi_cs_b                    chip select, active-low
//   busy, owner                 FSM not idle; current/last granted requester
//
// state | meaning
// IDLE  | waiting for a grant
// SETUP | cs_b low, waiting CS_SETUP cycles before the first bit
// SHIFT | bits moving on sclk/sd0/sd1
// HOLD  | cs_b still low for CS_HOLD cycles after the last falling sclk
// DONE  | cs_b high, response pulse to the owner, no grant this cycle
module usi_spi_sched
    import usi_spi_pkg::*;
#(
    parameter int CLK_DIV  = CLK_DIV_DEF,
    parameter int CS_SETUP = CS_SETUP_DEF,
    parameter int CS_HOLD  = CS_HOLD_DEF
) (
    input  logic              clk,
    input  logic              pad_cpu_rst_b,
    input  logic              en,
    input  logic              req0_valid,
    input  logic              req1_valid,
    output logic              req0_ready,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [LEN_W-1:0]  req0_len,
    input  logic [LEN_W-1:0]  req1_len,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              usi0_sclk_out,
    output logic              usi0_sclk_oe,
    output logic              usi0_sd0_out,
    output logic              usi0_sd0_oe,
    input  logic              usi0_sd1_in,
    output logic              spi_cs_b,
    output logic              busy,
    output logic              owner
);

    localparam logic [3:0] SETUP_LD = (CS_SETUP > 0) ? 4'(CS_SETUP - 1) : 4'd0;
    localparam logic [3:0] HOLD_LD  = (CS_HOLD  > 0) ? 4'(CS_HOLD  - 1) : 4'd0;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  tmr;
    logic        rr_last;
    logic        owner_q;
    logic        oe_q;
    logic        grant_ok;
    logic        gnt1;
    logic        accept;
    logic        shift_run;
    logic        shift_last;

    // Gated by reset so no handshake can complete while reset is held.
    assign grant_ok   = pad_cpu_rst_b && en && (state == IDLE);
    // On a tie the requester not granted last wins.
    assign gnt1       = req1_valid && (!req0_valid || !rr_last);
    assign req0_ready = grant_ok && req0_valid && !gnt1;
    assign req1_ready = grant_ok && gnt1;
    assign accept     = req0_ready || req1_ready;

    usi_spi_shift #(
        .CLK_DIV (CLK_DIV)
    ) u_shift (
        .clk     (clk),
        .rst_b   (pad_cpu_rst_b),
        .load    (accept),
        .run     (shift_run),
        .data    (gnt1 ? req1_data : req0_data),
        .len     (gnt1 ? req1_len  : req0_len),
        .sd1_in  (usi0_sd1_in),
        .sclk    (usi0_sclk_out),
        .sd0     (usi0_sd0_out),
        .last    (shift_last),
        .rx_data (rsp_data)
    );

    always_ff @(posedge clk) begin
        if (!pad_cpu_rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!pad_cpu_rst_b) begin
            tmr     <= '0;
            owner_q <= 1'b0;
            rr_last <= 1'b1;
            oe_q    <= 1'b0;
        end else begin
            oe_q <= 1'b1;
            if (accept) begin
                owner_q <= gnt1;
                rr_last <= gnt1;
                tmr     <= SETUP_LD;
            end else if (state == SHIFT && shift_last) begin
                tmr <= HOLD_LD;
            end else if ((state == SETUP || state == HOLD) && tmr != 4'd0) begin
                tmr <= tmr - 4'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)     state_nxt = (CS_SETUP == 0) ? SHIFT : SETUP;
            SETUP:   if (tmr == 4'd0) state_nxt = SHIFT;
            SHIFT:   if (shift_last) state_nxt = (CS_HOLD == 0) ? DONE : HOLD;
            HOLD:    if (tmr == 4'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        spi_cs_b     = !(state == SETUP || state == SHIFT || state == HOLD);
        busy         = (state != IDLE);
        shift_run    = (state == SHIFT);
        rsp0_valid   = (state == DONE) && !owner_q;
        rsp1_valid   = (state == DONE) && owner_q;
        owner        = owner_q;
        usi0_sclk_oe = oe_q;
        usi0_sd0_oe  = oe_q;
    end

endmodule

// File: tb/tb_usi_spi_sched.sv
module tb_usi_spi_sched;

    localparam int CLK_DIV  = 2;
    localparam int CS_SETUP = 1;
    localparam int CS_HOLD  = 1;
    localparam int PER_BIT  = 2 * CLK_DIV;

    logic        clk = 1'b0;
    logic        pad_cpu_rst_b = 1'b0;
    logic        en = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [15:0] req0_data = '0, req1_data = '0;
    logic [4:0]  req0_len = '0, req1_len = '0;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [15:0] rsp_data;
    logic        usi0_sclk_out, usi0_sclk_oe, usi0_sd0_out, usi0_sd0_oe, usi0_sd1_in;
    logic        spi_cs_b, busy, owner;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    usi_spi_sched #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) dut (
        .clk(clk), .pad_cpu_rst_b(pad_cpu_rst_b), .en(en),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_data(req0_data), .req1_data(req1_data),
        .req0_len(req0_len), .req1_len(req1_len),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
        .usi0_sclk_out(usi0_sclk_out), .usi0_sclk_oe(usi0_sclk_oe),
        .usi0_sd0_out(usi0_sd0_out), .usi0_sd0_oe(usi0_sd0_oe),
        .usi0_sd1_in(usi0_sd1_in), .spi_cs_b(spi_cs_b), .busy(busy), .owner(owner)
    );

    // Slave: rotating 16-bit register, shifts on sclk falling edge.
    logic [15:0] slave_sr = 16'h203D;
    always @(negedge usi0_sclk_out or negedge pad_cpu_rst_b)
        if (!pad_cpu_rst_b) slave_sr <= 16'h203D;
        else                slave_sr <= {slave_sr[14:0], slave_sr[15]};
    assign usi0_sd1_in = slave_sr[15];

    int sclk_pulses = 0;
    bit mosi_log [4096];
    always @(posedge usi0_sclk_out) begin
        mosi_log[sclk_pulses % 4096] = usi0_sd0_out;
        sclk_pulses++;
    end

    int cyc = 0;
    bit rst_edge = 1'b0;
    always @(posedge clk) begin
        cyc++;
        rst_edge = !pad_cpu_rst_b;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model of one transfer, plus logs of grants and observed responses.
    bit          m_active = 1'b0;
    int          m_t0, m_len;
    logic        m_owner = 1'b0, m_rr = 1'b1;
    logic [15:0] m_rx, m_tx;
    logic [15:0] mslave = 16'h203D;
    int          pulse_base = 0;
    int          g_n = 0, d_n = 0;
    int          g_cyc [32];
    logic        g_id [32];
    int          d_cyc [32], d_pulses [32];
    logic        d_own [32];
    logic [15:0] d_data [32], d_mosi [32];

    always @(negedge clk) begin
        int k, done_k, sh0, pulses, l;
        bit idle_now;
        logic e_sclk, g1, e_r0, e_r1;
        logic [15:0] mb;
        logic [31:0] rot;
        if (cyc > 0) begin
            pulses = sclk_pulses - pulse_base;
            mb = '0;
            for (int i = 0; i < pulses && i < 16; i++)
                mb = {mb[14:0], mosi_log[(pulse_base + i) % 4096]};
            if ((rsp0_valid || rsp1_valid) && d_n < 32) begin
                d_cyc[d_n] = cyc; d_own[d_n] = rsp1_valid; d_data[d_n] = rsp_data;
                d_pulses[d_n] = pulses; d_mosi[d_n] = mb; d_n++;
            end
            idle_now = !m_active || rst_edge;
            if (rst_edge) begin
                chk("rst_cs_b", spi_cs_b, 1);      chk("rst_sclk", usi0_sclk_out, 0);
                chk("rst_sclk_oe", usi0_sclk_oe, 0); chk("rst_sd0_oe", usi0_sd0_oe, 0);
                chk("rst_sd0", usi0_sd0_out, 0);   chk("rst_rsp0", rsp0_valid, 0);
                chk("rst_rsp1", rsp1_valid, 0);    chk("rst_rsp_data", rsp_data, 0);
                chk("rst_busy", busy, 0);          chk("rst_owner", owner, 0);
                m_active = 1'b0; m_rr = 1'b1; m_owner = 1'b0; mslave = 16'h203D;
            end else begin
                chk("sclk_oe", usi0_sclk_oe, 1);
                chk("sd0_oe", usi0_sd0_oe, 1);
                if (m_active) begin
                    k = cyc - m_t0;
                    sh0 = 1 + CS_SETUP;
                    done_k = sh0 + PER_BIT * m_len + CS_HOLD;
                    e_sclk = (k >= sh0) && (k < sh0 + PER_BIT * m_len) && ((k - sh0) % PER_BIT >= CLK_DIV);
                    chk("cs_b", spi_cs_b, k >= done_k);
                    chk("sclk", usi0_sclk_out, e_sclk);
                    chk("busy", busy, 1);
                    chk("owner", owner, m_owner);
                    chk("rsp0", rsp0_valid, (k == done_k) && !m_owner);
                    chk("rsp1", rsp1_valid, (k == done_k) && m_owner);
                    chk("ready0_busy", req0_ready, 0);
                    chk("ready1_busy", req1_ready, 0);
                    if (k == done_k) begin
                        chk("rsp_data", rsp_data, m_rx);
                        chk("sclk_pulses", pulses, m_len);
                        chk("mosi_bits", mb, m_tx >> (16 - m_len));
                        m_active = 1'b0;
                    end
                end else begin
                    chk("idle_cs_b", spi_cs_b, 1);
                    chk("idle_sclk", usi0_sclk_out, 0);
                    chk("idle_busy", busy, 0);
                    chk("idle_rsp0", rsp0_valid, 0);
                    chk("idle_rsp1", rsp1_valid, 0);
                    chk("idle_owner", owner, m_owner);
                end
            end
            if (idle_now) begin
                g1   = req1_valid && (!req0_valid || !m_rr);
                e_r0 = pad_cpu_rst_b && en && req0_valid && !g1;
                e_r1 = pad_cpu_rst_b && en && g1;
                chk("ready0", req0_ready, e_r0);
                chk("ready1", req1_ready, e_r1);
                if (e_r0 || e_r1) begin
                    m_active = 1'b1; m_t0 = cyc; m_owner = e_r1; m_rr = e_r1;
                    m_tx = e_r1 ? req1_data : req0_data;
                    l = e_r1 ? int'(req1_len) : int'(req0_len);
                    m_len = (l == 0 || l > 16) ? 16 : l;
                    m_rx = mslave >> (16 - m_len);
                    rot = {mslave, mslave} << m_len;
                    mslave = rot[31:16];
                    pulse_base = sclk_pulses;
                    if (g_n < 32) begin g_cyc[g_n] = cyc; g_id[g_n] = e_r1; g_n++; end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic id, input logic [15:0] d, input logic [4:0] l);
        bit got = 1'b0;
        if (id) begin req1_valid = 1; req1_data = d; req1_len = l; end
        else    begin req0_valid = 1; req0_data = d; req0_len = l; end
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            got = id ? req1_ready : req0_ready;
            @(posedge clk); #1;
        end
        chk("send_accepted", got, 1);
        if (id) begin req1_valid = 0; req1_data = 16'($urandom); req1_len = 5'($urandom); end
        else    begin req0_valid = 0; req0_data = 16'($urandom); req0_len = 5'($urandom); end
    endtask

    task automatic send_both(input logic [15:0] d0, input logic [4:0] l0,
                             input logic [15:0] d1, input logic [4:0] l1);
        bit s0, s1;
        req0_valid = 1; req0_data = d0; req0_len = l0;
        req1_valid = 1; req1_data = d1; req1_len = l1;
        for (int i = 0; i < 600 && (req0_valid || req1_valid); i++) begin
            @(negedge clk);
            s0 = req0_ready; s1 = req1_ready;
            @(posedge clk); #1;
            if (s0) begin req0_valid = 0; req0_data = 16'($urandom); end
            if (s1) begin req1_valid = 0; req1_data = 16'($urandom); end
        end
        chk("both_accepted", {req0_valid, req1_valid}, 0);
        req0_valid = 0; req1_valid = 0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            tick(1);
            done = !busy;
        end
        chk("wait_idle", done, 1);
        tick(1);
    endtask

    initial begin
        int g, d, seen;
        tick(3);
        pad_cpu_rst_b = 1; en = 1;
        tick(2);

        // Full 16-bit word from requester 0
        g = g_n; d = d_n;
        send(0, 16'hA5C3, 5'd16);
        wait_idle();
        chk("t1_rsp_count", d_n, d + 1);
        chk("t1_latency", d_cyc[d] - g_cyc[g], 67);
        chk("t1_rsp_data", d_data[d], 16'h203D);
        chk("t1_mosi", d_mosi[d], 16'hA5C3);
        chk("t1_pulses", d_pulses[d], 16);
        chk("t1_owner", d_own[d], 0);

        // Ties after reset: 0, then 1 after one idle cycle, then 0 again
        pad_cpu_rst_b = 0; tick(2); pad_cpu_rst_b = 1;
        g = g_n; d = d_n;
        send_both(16'h1234, 5'd16, 16'hC0DE, 5'd8);
        wait_idle();
        send_both(16'h5A5A, 5'd4, 16'h0FF0, 5'd12);
        wait_idle();
        chk("tie1_winner", g_id[g], 0);
        chk("tie1_second", g_id[g + 1], 1);
        chk("tie3_winner", g_id[g + 2], 0);
        chk("tie_gap", g_cyc[g + 1] - d_cyc[d], 1);
        chk("tie_rx_second", d_data[d + 1], 16'h0020);

        // Short word from requester 1
        g = g_n; d = d_n;
        send(1, 16'hF000, 5'd4);
        wait_idle();
        chk("len4_pulses", d_pulses[d], 4);
        chk("len4_mosi", d_mosi[d], 16'h000F);
        chk("len4_upper_zero", d_data[d] >> 4, 0);
        chk("len4_owner", d_own[d], 1);
        chk("len4_latency", d_cyc[d] - g_cyc[g], 19);

        // len 0 and len 20 behave as 16
        g = g_n; d = d_n;
        send(0, 16'h3C96, 5'd0);
        wait_idle();
        chk("len0_pulses", d_pulses[d], 16);
        chk("len0_latency", d_cyc[d] - g_cyc[g], 67);
        chk("len0_mosi", d_mosi[d], 16'h3C96);
        d = d_n;
        send(1, 16'h8421, 5'd20);
        wait_idle();
        chk("len20_pulses", d_pulses[d], 16);

        // en low blocks grants; dropping en mid-transfer does not abort
        en = 0; req0_valid = 1; req0_data = 16'h0F0F; req0_len = 5'd8; seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (req0_ready) seen++;
            @(posedge clk); #1;
        end
        chk("en_low_no_ready", seen, 0);
        chk("en_low_idle", busy, 0);
        en = 1; d = d_n;
        send(0, 16'h0F0F, 5'd8);
        tick(10);
        en = 0;
        wait_idle();
        chk("en_drop_rsp", d_n, d + 1);
        chk("en_drop_owner", d_own[d], 0);
        en = 1;

        // Reset during bit 7 aborts with no response
        d = d_n;
        send(0, 16'hBEEF, 5'd16);
        tick(29);
        pad_cpu_rst_b = 0;
        tick(1);
        chk("abort_cs_b", spi_cs_b, 1);
        chk("abort_sclk", usi0_sclk_out, 0);
        tick(1);
        pad_cpu_rst_b = 1;
        tick(80);
        chk("abort_no_rsp", d_n, d);
        send(0, 16'h6E17, 5'd16);
        wait_idle();
        chk("post_abort_rsp", d_n, d + 1);
        chk("post_abort_data", d_data[d], 16'h203D);
        chk("post_abort_mosi", d_mosi[d], 16'h6E17);

        tick(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/usi_spi_sched.md
USI_SPI_SCHED -- requirements
Module: usi_spi_sched

Interface
- REQ-001 Parameter CLK_DIV, default 2: sclk half-period in clk cycles (legal range 1..255).
- REQ-002 Parameter CS_SETUP, default 1: clk cycles from cs_b falling to the first bit phase (0..15).
- REQ-003 Parameter CS_HOLD, default 1: clk cycles from the last sclk falling edge to cs_b rising (0..15).
- REQ-004 clk  in  1  the single block clock; all state updates on its rising edge.
- REQ-005 pad_cpu_rst_b  in  1  reset, synchronous, active-low.
- REQ-006 en  in  1  grants are permitted only while high.
- REQ-007 req0_valid / req1_valid  in  1  transfer request from requester 0 / 1.
- REQ-008 req0_ready / req1_ready  out  1  request accepted this cycle.
- REQ-009 req0_data / req1_data  in  16  TX word, left-aligned, MSB first.
- REQ-010 req0_len / req1_len  in  5  bit count; 1..16 are used as given, 0 and 17..31 are treated as 16.
- REQ-011 rsp0_valid / rsp1_valid  out  1  one-cycle completion pulse to the owner.
- REQ-012 rsp_data  out  16  RX bits, right-aligned, upper bits zero; valid while any rsp*_valid is high.
- REQ-013 usi0_sclk_out, usi0_sclk_oe  out  1 each  serial clock and its output enable.
- REQ-014 usi0_sd0_out, usi0_sd0_oe  out  1 each  MOSI and its output enable.
- REQ-015 usi0_sd1_in  in  1  MISO.
- REQ-016 spi_cs_b  out  1  chip select, active-low.
- REQ-017 busy  out  1  FSM is not in IDLE.
- REQ-018 owner  out  1  id of the current or last granted requester.

Function
- REQ-019 The FSM SHALL have states IDLE, SETUP, SHIFT, HOLD, DONE.
- REQ-020 In IDLE with en=1, exactly one reqN_ready SHALL assert combinationally:
  - for the single valid requester, or
  - by round-robin when both are valid: the requester not granted last wins.
- REQ-021 The round-robin pointer SHALL reset so that requester 0 wins the first tie.
- REQ-022 On the valid&ready cycle T:
  - data, effective length and owner SHALL be latched;
  - the FSM goes to SETUP;
  - spi_cs_b goes low at T+1.
- REQ-023 SETUP SHALL last CS_SETUP cycles; when CS_SETUP=0 the FSM goes directly to SHIFT.
- REQ-024 SHIFT uses SPI mode 0:
  - each bit is CLK_DIV cycles with sclk low, then CLK_DIV cycles with sclk high;
  - sd0_out SHALL change only while sclk is low;
  - sd1_in SHALL be sampled on the clk edge where sclk goes high.
- REQ-025 Sampled bits SHALL shift into the RX register LSB-first-in, so the first bit received ends up as bit len-1.
- REQ-026 After the last bit's high phase, sclk SHALL return low; HOLD then lasts CS_HOLD cycles.
- REQ-027 In DONE (one cycle):
  - spi_cs_b SHALL be high;
  - rsp<owner>_valid SHALL be high for exactly one cycle;
  - the FSM then returns to IDLE.
- REQ-028 The rsp pulse cycle SHALL be T+1+CS_SETUP+2*CLK_DIV*len+CS_HOLD.
- REQ-029 No new grant SHALL occur in the DONE cycle, giving a minimum 1-cycle gap between transfers.
- REQ-030 Requesters SHALL hold data and len stable while valid until ready; the block SHALL ignore input changes after acceptance.
- REQ-031 Deasserting en mid-transfer SHALL NOT abort the transfer; it only blocks new grants.
- REQ-032 rsp has no backpressure; a missed pulse is lost.

Reset
- REQ-033 While pad_cpu_rst_b=0 at a clk edge:
  - FSM=IDLE;
  - spi_cs_b=1, usi0_sclk_out=0, usi0_sd0_out=0, usi0_sclk_oe=0, usi0_sd0_oe=0;
  - reqN_ready=0, rspN_valid=0, rsp_data=0, busy=0, owner=0, RR pointer=1.
- REQ-034 Both output enables SHALL go to 1 on the first edge after reset is released and stay at 1.
- REQ-035 Reset mid-transfer SHALL abort immediately with no response pulse; the next transfer SHALL start from a clean state.

Structure
- REQ-036 Package usi_spi_pkg SHALL hold:
  - the state enum;
  - LEN_W=5 and DATA_W=16;
  - default values of CLK_DIV, CS_SETUP and CS_HOLD.
- REQ-037 Sub-module usi_spi_shift SHALL own the divider counter, bit counter, TX/RX shift registers and sclk generation.
- REQ-038 usi_spi_sched SHALL own arbitration, the FSM and response routing.

Verification
- REQ-039 Bench slave: shifts a 16-bit register left, rotating, on sclk negedge; reset value 16'h203D; miso = bit15. Test 1: req0 with data 16'hA5C3, len 16, accepted at T → MOSI stream A5C3, rsp0_valid at T+67, rsp_data=16'h203D.
- REQ-040 Both requesters valid in IDLE after reset → req0 served first, then req1 after a 1-cycle gap; a third tie goes to req0 again.
- REQ-041 req1 with len=4, data 16'hF000 → exactly 4 sclk pulses, MOSI 1111, rsp_data[15:4]=0.
- REQ-042 len=0 → behaves exactly as len=16, with 16 sclk pulses.
- REQ-043 Reset asserted at bit 7 of a transfer → next cycle spi_cs_b=1, sclk=0, no rsp pulse; a following transfer completes correctly.
- REQ-044 en=0 with req0_valid=1 → req0_ready stays 0; en dropped mid-transfer → transfer completes and rsp is issued.
